// File: rtl/ring_osc_sweep_ctrl.sv
// ring_osc_sweep_ctrl: steps the ring oscillator through one tap or a 0..7 sweep,
// settling each tap, counting osc edges over a fixed clk window and streaming the result.
module ring_osc_sweep_ctrl #(
    parameter int CW     = 16,
    parameter int SETTLE = 16,
    parameter int WINDOW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          single,
    input  logic [2:0]    tap_sel,
    input  logic          abort,
    input  logic [CW-1:0] osc_cnt,
    output logic [2:0]    tap,
    output logic          osc_en,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    res_tap,
    output logic [CW-1:0] res_count,
    output logic          done
);
    localparam int MX = SETTLE > WINDOW ? SETTLE : WINDOW;
    localparam int TW = MX > 1 ? $clog2(MX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

    state_t        state, nxt;
    logic [TW-1:0] timer;
    logic [CW-1:0] base;
    logic          single_l, last, tmo, kill;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        tmo  = timer == '0;
        kill = state != S_IDLE && abort;
        last = single_l || tap == 3'd7;
        nxt  = kill                              ? S_IDLE    :
               (state == S_IDLE    && start)     ? S_SETTLE  :
               (state == S_SETTLE  && tmo)       ? S_MEASURE :
               (state == S_MEASURE && tmo)       ? S_REPORT  :
               (state == S_REPORT  && res_ready) ? (last ? S_IDLE : S_SETTLE) :
                                                   state;
    end

    always_comb begin
        osc_en    = state == S_SETTLE || state == S_MEASURE;
        busy      = state != S_IDLE;
        res_valid = state == S_REPORT;
    end

    // Abort leaves tap and the last result untouched; only the state collapses to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= '0;
            base      <= '0;
            single_l  <= 1'b0;
            tap       <= 3'd0;
            res_tap   <= 3'd0;
            res_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!kill) begin
                case (state)
                    S_IDLE: if (start) begin
                        single_l <= single;
                        tap      <= single ? tap_sel : 3'd0;
                        timer    <= TW'(SETTLE - 1);
                    end
                    S_SETTLE: begin
                        timer <= tmo ? TW'(WINDOW - 1) : timer - TW'(1);
                        if (tmo) base <= osc_cnt;
                    end
                    S_MEASURE: begin
                        timer <= timer - TW'(1);
                        if (tmo) begin
                            res_count <= osc_cnt - base;
                            res_tap   <= tap;
                        end
                    end
                    S_REPORT: if (res_ready) begin
                        if (last) done <= 1'b1;
                        else begin
                            tap   <= tap + 3'd1;
                            timer <= TW'(SETTLE - 1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ring_osc_sweep_ctrl.sv
// tb_ring_osc_sweep_ctrl: directed plus randomized runs checked against a cycle-indexed
// history of osc_cnt; two instances cover WINDOW=16 and WINDOW=32.
module tb_ring_osc_sweep_ctrl;
    localparam int S = 4;

    logic        clk = 0, rst = 1, start = 0, single = 0, abort = 0, res_ready = 0, sel = 0;
    logic [2:0]  tap_sel = 0;
    logic [15:0] osc_cnt = 0, inc = 0, last_cnt;
    bit          rnd = 0;
    int          checks = 0, errors = 0, n = 0;
    logic [15:0] hist [0:16383];

    logic [2:0]  tap_a, res_tap_a, tap_b, res_tap_b, tap_o, res_tap_o;
    logic [15:0] res_count_a, res_count_b, res_count_o;
    logic        osc_en_a, busy_a, res_valid_a, done_a, osc_en_b, busy_b, res_valid_b, done_b;
    logic        osc_en_o, busy_o, res_valid_o, done_o;

    ring_osc_sweep_ctrl #(.CW(16), .SETTLE(S), .WINDOW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .single(single), .tap_sel(tap_sel),
        .abort(abort), .osc_cnt(osc_cnt), .tap(tap_a), .osc_en(osc_en_a), .busy(busy_a),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_tap(res_tap_a),
        .res_count(res_count_a), .done(done_a));

    ring_osc_sweep_ctrl #(.CW(16), .SETTLE(S), .WINDOW(32)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .single(single), .tap_sel(tap_sel),
        .abort(abort), .osc_cnt(osc_cnt), .tap(tap_b), .osc_en(osc_en_b), .busy(busy_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_tap(res_tap_b),
        .res_count(res_count_b), .done(done_b));

    assign tap_o       = sel ? tap_b       : tap_a;
    assign res_tap_o   = sel ? res_tap_b   : res_tap_a;
    assign res_count_o = sel ? res_count_b : res_count_a;
    assign osc_en_o    = sel ? osc_en_b    : osc_en_a;
    assign busy_o      = sel ? busy_b      : busy_a;
    assign res_valid_o = sel ? res_valid_b : res_valid_a;
    assign done_o      = sel ? done_b      : done_a;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hist[k] is the osc_cnt value the DUT sees at edge k.
    task automatic tick();
        if (n < 16384) hist[n] = osc_cnt;
        @(posedge clk);
        #1;
        n++;
        osc_cnt = osc_cnt + (rnd ? 16'($urandom_range(0, 7)) : inc);
    endtask

    task automatic run(input bit sgl, input logic [2:0] ts, input int smin, input int smax);
        int w, e0, ntap, d;
        logic [2:0]  et;
        logic [15:0] ec;
        w    = sel ? 32 : 16;
        ntap = sgl ? 1 : 8;
        single = sgl; tap_sel = ts; start = 1;
        tick();
        start = 0;
        e0 = n - 1;
        for (int i = 0; i < ntap; i++) begin
            et = sgl ? ts : 3'(i);
            chk("tap_set", 32'(tap_o), 32'(et));
            chk("osc_en_on", 32'(osc_en_o), 1);
            for (int k = 0; k < 200 && !res_valid_o; k++) tick();
            chk("latency", n - 1 - e0, S + w);
            ec = hist[e0 + S + w] - hist[e0 + S];
            last_cnt = res_count_o;
            chk("res_tap", 32'(res_tap_o), 32'(et));
            chk("res_count", 32'(res_count_o), 32'(ec));
            chk("osc_en_report", 32'(osc_en_o), 0);
            d = $urandom_range(smax, smin);
            for (int j = 0; j < d; j++) begin
                tick();
                chk("hold_valid", 32'(res_valid_o), 1);
                chk("hold_count", 32'(res_count_o), 32'(ec));
                chk("hold_res_tap", 32'(res_tap_o), 32'(et));
                chk("hold_osc_en", 32'(osc_en_o), 0);
                chk("hold_tap", 32'(tap_o), 32'(et));
            end
            res_ready = 1;
            tick();
            res_ready = 0;
            chk("valid_drop", 32'(res_valid_o), 0);
            if (i == ntap - 1) begin
                chk("done_pulse", 32'(done_o), 1);
                chk("busy_end", 32'(busy_o), 0);
                tick();
                chk("done_clear", 32'(done_o), 0);
            end else begin
                chk("no_done_mid", 32'(done_o), 0);
                chk("busy_mid", 32'(busy_o), 1);
                e0 = n - 1;
            end
        end
    endtask

    initial begin
        bit bad;
        logic [2:0] t0;
        int e0;
        // reset
        rst = 1;
        repeat (3) tick();
        chk("rst_tap", 32'(tap_a), 0);
        chk("rst_osc_en", 32'(osc_en_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_valid", 32'(res_valid_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        rst = 0;
        tick();
        // single tap 5, +3 per cycle
        inc = 3;
        run(1, 3'd5, 0, 0);
        chk("cnt48", 32'(last_cnt), 48);
        // full sweep, immediate ready, then a random-stall sweep
        rnd = 1;
        run(0, 3'd0, 0, 0);
        run(0, 3'($urandom), 0, 3);
        // 10-cycle backpressure
        run(1, 3'($urandom), 10, 10);
        // wrap at window start on the WINDOW=32 instance
        sel = 1; rnd = 0; inc = 1;
        osc_cnt = 16'hFFF0 - 16'(S);
        run(1, 3'($urandom), 0, 0);
        chk("wrap32", 32'(last_cnt), 32);
        sel = 0; rnd = 1;
        // abort in MEASURE with a stray start during SETTLE
        t0 = 3'($urandom_range(0, 6));
        single = 1; tap_sel = t0; start = 1;
        tick();
        start = 0;
        e0 = n - 1;
        tick();
        tap_sel = t0 + 3'd1; single = 0; start = 1;
        tick();
        start = 0;
        while (n - 1 < e0 + S + 4) tick();
        chk("pre_abort_busy", 32'(busy_o), 1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_osc_en", 32'(osc_en_o), 0);
        chk("abort_valid", 32'(res_valid_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_tap", 32'(tap_o), 32'(t0));
        bad = 0;
        repeat (40) begin
            tick();
            if (res_valid_o || done_o || busy_o) bad = 1;
        end
        chk("abort_quiet", 32'(bad), 0);
        // start beats abort in IDLE, then abort in SETTLE
        single = 1; tap_sel = 3'd3; start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("start_wins", 32'(busy_o), 1);
        chk("start_wins_tap", 32'(tap_o), 3);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_settle", 32'(busy_o), 0);
        tick();
        // randomized runs
        for (int r = 0; r < 6; r++) run(1'($urandom_range(0, 1)), 3'($urandom), 0, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
